ps2_scancode_rx: RTL

// - PS/2 keyboard receive front end. It sits directly upstream of the paddle

---
 rtl/ps2_scancode_rx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the pins, deframes
// 11-bit frames and folds E0/F0 prefixes into single key events.
module ps2_scancode_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              clk_sync_reg;
    logic [1:0]              data_sync_reg;
    logic [FILTER_LEN-1:0]   hist_reg;
    logic                    filt_reg;
    logic                    fall_reg;
    logic [2:0]              bit_cnt_reg;
    logic [7:0]              shift_reg;
    logic                    parity_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    ext_pend_reg;
    logic                    brk_pend_reg;
    logic [7:0]              key_code_reg;
    logic                    key_ext_reg;
    logic                    key_break_reg;
    logic                    key_valid_reg;
    logic                    frame_err_reg;

    logic                    data_bit;
    logic                    all_low;
    logic                    all_high;
    logic                    timeout;
    logic                    frame_ok;
    logic                    frame_bad;

    assign data_bit = data_sync_reg[1];
    assign all_low  = ~|hist_reg;
    assign all_high = &hist_reg;
    assign cnt_inc  = cnt_reg + 1'b1;

    // The timeout fires on the edge where the counter would reach TIMEOUT-1,
    // so frame_err lands exactly TIMEOUT cycles after the last fall.
    always_comb begin
        state_next = state_reg;
        timeout    = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        if (state_reg != IDLE && !fall_reg && cnt_inc == CNT_W'(TIMEOUT - 1)) begin
            timeout    = 1'b1;
            state_next = IDLE;
        end else if (fall_reg) begin
            case (state_reg)
                IDLE: begin
                    if (!data_bit) state_next = DATA;
                end
                DATA: begin
                    if (bit_cnt_reg == 3'd7) state_next = PARITY;
                end
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    if (data_bit && (^{shift_reg, parity_reg}))
                        frame_ok = 1'b1;
                    else
                        frame_bad = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            hist_reg      <= '1;
            filt_reg      <= 1'b1;
            fall_reg      <= 1'b0;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            parity_reg    <= 1'b0;
            cnt_reg       <= '0;
            ext_pend_reg  <= 1'b0;
            brk_pend_reg  <= 1'b0;
            key_code_reg  <= 8'd0;
            key_ext_reg   <= 1'b0;
            key_break_reg <= 1'b0;
            key_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            key_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;

            clk_sync_reg  <= {clk_sync_reg[0], ps2Clk};
            data_sync_reg <= {data_sync_reg[0], ps2Data};
            hist_reg      <= {hist_reg[FILTER_LEN-2:0], clk_sync_reg[1]};

            // Filtered clock only moves when the whole history agrees.
            if (all_low)
                filt_reg <= 1'b0;
            else if (all_high)
                filt_reg <= 1'b1;
            fall_reg <= filt_reg & all_low;

            if (fall_reg) begin
                case (state_reg)
                    IDLE:   bit_cnt_reg <= 3'd0;
                    DATA: begin
                        shift_reg   <= {data_bit, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    end
                    PARITY: parity_reg <= data_bit;
                    default: ;
                endcase
            end

            if (state_reg == IDLE || fall_reg || timeout)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_inc;

            if (frame_ok) begin
                if (shift_reg == 8'hE0) begin
                    ext_pend_reg <= 1'b1;
                end else if (shift_reg == 8'hF0) begin
                    brk_pend_reg <= 1'b1;
                end else begin
                    key_code_reg  <= shift_reg;
                    key_ext_reg   <= ext_pend_reg;
                    key_break_reg <= brk_pend_reg;
                    key_valid_reg <= 1'b1;
                    ext_pend_reg  <= 1'b0;
                    brk_pend_reg  <= 1'b0;
                end
            end

            if (frame_bad || timeout) begin
                frame_err_reg <= 1'b1;
                ext_pend_reg  <= 1'b0;
                brk_pend_reg  <= 1'b0;
            end
        end
    end

    assign key_code  = key_code_reg;
    assign key_ext   = key_ext_reg;
    assign key_break = key_break_reg;
    assign key_valid = key_valid_reg;
    assign frame_err = frame_err_reg;

endmodule
